// File: rtl/line_pkg.sv
// Shared types and constants for the Bresenham line rasteriser.
package line_pkg;

  localparam int DefCordW  = 16;
  // Extra bits on dx/dy/err so |xe-xs| and dx+dy never overflow.
  localparam int ErrExtraW = 2;
  localparam int DefErrW   = DefCordW + ErrExtraW;

  typedef logic signed [DefCordW-1:0] coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StDraw,
    StDone
  } state_e;

endpackage

// File: rtl/line_clip_test.sv
// Combinational screen-bounds check: in_bounds_o when 0 <= x < SCREEN_W and 0 <= y < SCREEN_H.
module line_clip_test #(
  parameter int CORDW    = 16,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic signed [CORDW-1:0] x_i,
  input  logic signed [CORDW-1:0] y_i,
  output logic                    in_bounds_o
);

  localparam logic [CORDW-1:0] WLim = CORDW'(SCREEN_W);
  localparam logic [CORDW-1:0] HLim = CORDW'(SCREEN_H);

  // Negative values are rejected by the sign bit, so the limit compare can be unsigned.
  assign in_bounds_o = ~x_i[CORDW-1] & ~y_i[CORDW-1] &
                       ($unsigned(x_i) < WLim) & ($unsigned(y_i) < HLim);

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser emitting one pixel per cycle on a valid/ready stream.
// Define LINE_RASTER_CLIP_EN to drop pixels outside SCREEN_W x SCREEN_H.
module line_raster
  import line_pkg::*;
#(
  parameter int CORDW    = 16,
  parameter int COLORW   = 12,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_start,
  input  logic signed [CORDW-1:0] io_xs,
  input  logic signed [CORDW-1:0] io_ys,
  input  logic signed [CORDW-1:0] io_xe,
  input  logic signed [CORDW-1:0] io_ye,
  input  logic [COLORW-1:0]       io_color,
  output logic                    io_busy,
  output logic                    io_pixValid,
  input  logic                    io_pixReady,
  output logic signed [CORDW-1:0] io_writeX,
  output logic signed [CORDW-1:0] io_writeY,
  output logic [COLORW-1:0]       io_pixColor,
  output logic                    io_done
);

  localparam int ErrW = CORDW + ErrExtraW;

  typedef logic signed [CORDW-1:0] crd_t;
  typedef logic signed [ErrW-1:0]  err_t;

  state_e            state_q, state_d;
  crd_t              xs_q, ys_q, xe_q, ye_q, x_q, y_q;
  crd_t              xs_d, ys_d, xe_d, ye_d, x_d, y_d;
  logic [COLORW-1:0] color_q, color_d;
  err_t              dx_q, dy_q, err_q, dx_d, dy_d, err_d;
  logic              sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;

  err_t              dx_raw, dy_raw, dx_abs, dy_abs;
  logic signed [ErrW:0] e2;
  logic              step_x, step_y, at_end, clipped, retire;

  assign dx_raw = err_t'(xe_q) - err_t'(xs_q);
  assign dy_raw = err_t'(ye_q) - err_t'(ys_q);
  assign dx_abs = dx_raw[ErrW-1] ? -dx_raw : dx_raw;
  assign dy_abs = dy_raw[ErrW-1] ? -dy_raw : dy_raw;

  assign e2     = {err_q, 1'b0};
  assign step_x = e2 >= (ErrW+1)'(dy_q);
  assign step_y = e2 <= (ErrW+1)'(dx_q);
  assign at_end = (x_q == xe_q) && (y_q == ye_q);

`ifdef LINE_RASTER_CLIP_EN
  logic in_bounds;

  line_clip_test #(
    .CORDW    (CORDW),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .x_i         (x_q),
    .y_i         (y_q),
    .in_bounds_o (in_bounds)
  );

  assign clipped = ~in_bounds;
`else
  assign clipped = 1'b0;
`endif

  // A clipped pixel retires without waiting for the consumer.
  assign retire = (state_q == StDraw) && (clipped || io_pixReady);

  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    unique case (state_q)
      StIdle: begin
        if (io_start) begin
          xs_d    = io_xs;
          ys_d    = io_ys;
          xe_d    = io_xe;
          ye_d    = io_ye;
          color_d = io_color;
          state_d = StInit;
        end
      end
      StInit: begin
        dx_d     = dx_abs;
        dy_d     = -dy_abs;
        err_d    = dx_abs - dy_abs;
        sx_neg_d = xs_q >= xe_q;
        sy_neg_d = ys_q >= ye_q;
        x_d      = xs_q;
        y_d      = ys_q;
        state_d  = StDraw;
      end
      StDraw: begin
        if (retire) begin
          if (at_end) begin
            state_d = StDone;
          end else begin
            if (step_x) x_d = sx_neg_q ? x_q - crd_t'(1) : x_q + crd_t'(1);
            if (step_y) y_d = sy_neg_q ? y_q - crd_t'(1) : y_q + crd_t'(1);
            err_d = err_q + (step_x ? dy_q : err_t'(0)) + (step_y ? dx_q : err_t'(0));
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      xs_q     <= '0;
      ys_q     <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign io_busy     = (state_q != StIdle);
  assign io_pixValid = (state_q == StDraw) && !clipped;
  assign io_done     = (state_q == StDone);
  assign io_writeX   = x_q;
  assign io_writeY   = y_q;
  assign io_pixColor = color_q;

endmodule

// File: tb/tb_line_raster.sv
// Self-checking bench for line_raster against an integer Bresenham reference model.
module tb_line_raster;

  localparam int CORDW    = 16;
  localparam int COLORW   = 12;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic io_start = 1'b0;
  logic signed [CORDW-1:0] io_xs = '0, io_ys = '0, io_xe = '0, io_ye = '0;
  logic [COLORW-1:0] io_color = '0;
  logic io_busy, io_pixValid, io_done;
  logic io_pixReady = 1'b1;
  logic signed [CORDW-1:0] io_writeX, io_writeY;
  logic [COLORW-1:0] io_pixColor;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference results
  int exp_x[$];
  int exp_y[$];
  int exp_steps;

  // Captured results of the last run_line
  int got_x[$];
  int got_y[$];
  int got_c[$];
  int t_start, done_cyc, done_cnt, stall_cyc, hold_cyc, hold_bad;
  logic busy_after, busy_after2;

  line_raster #(
    .CORDW    (CORDW),
    .COLORW   (COLORW),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_xs       (io_xs),
    .io_ys       (io_ys),
    .io_xe       (io_xe),
    .io_ye       (io_ye),
    .io_color    (io_color),
    .io_busy     (io_busy),
    .io_pixValid (io_pixValid),
    .io_pixReady (io_pixReady),
    .io_writeX   (io_writeX),
    .io_writeY   (io_writeY),
    .io_pixColor (io_pixColor),
    .io_done     (io_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic bit visible(input int x, input int y);
`ifdef LINE_RASTER_CLIP_EN
    return (x >= 0) && (x < SCREEN_W) && (y >= 0) && (y < SCREEN_H);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_line(input int xs, input int ys, input int xe, input int ye);
    int dx, dy, sx, sy, err, e2, x, y;
    exp_x.delete();
    exp_y.delete();
    exp_steps = 0;
    dx  = (xe > xs) ? xe - xs : xs - xe;
    dy  = -((ye > ys) ? ye - ys : ys - ye);
    sx  = (xs < xe) ? 1 : -1;
    sy  = (ys < ye) ? 1 : -1;
    err = dx + dy;
    x   = xs;
    y   = ys;
    while (1) begin
      exp_steps++;
      if (visible(x, y)) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
      end
      if (x == xe && y == ye) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  // mode 1 = random ready; stall_idx = pixel index to hold ready low on (-1: none)
  task automatic run_line(input int xs, input int ys, input int xe, input int ye,
                          input logic [COLORW-1:0] col, input int mode, input int stall_idx,
                          input int stall_len, input int pulse_at, input int budget);
    int stalled;
    int hx, hy;
    logic rdy;
    got_x.delete();
    got_y.delete();
    got_c.delete();
    done_cyc = -1; done_cnt = 0; stall_cyc = 0; hold_cyc = 0; hold_bad = 0;
    busy_after = 1'bx; busy_after2 = 1'bx;
    stalled = 0; hx = 0; hy = 0;
    @(negedge clock);
    io_xs = CORDW'(xs); io_ys = CORDW'(ys); io_xe = CORDW'(xe); io_ye = CORDW'(ye);
    io_color = col;
    io_start = 1'b1;
    io_pixReady = 1'b1;
    t_start = cyc;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      io_start = (pulse_at > 0) && (k == pulse_at);
      if (io_start) begin
        io_xs = 16'sd3; io_ys = 16'sd3; io_xe = 16'sd90; io_ye = 16'sd7; io_color = ~col;
      end
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
      if (io_pixValid && got_x.size() == stall_idx) begin
        if (hold_cyc == 0) begin
          hx = int'(io_writeX); hy = int'(io_writeY);
        end else if (int'(io_writeX) != hx || int'(io_writeY) != hy || io_pixColor != col) begin
          hold_bad = 1;
        end
        hold_cyc++;
        if (stalled < stall_len) begin rdy = 1'b0; stalled++; end
      end
      io_pixReady = rdy;
      if (io_pixValid && !rdy) stall_cyc++;
      if (io_pixValid && rdy) begin
        got_x.push_back(int'(io_writeX));
        got_y.push_back(int'(io_writeY));
        got_c.push_back(int'(io_pixColor));
      end
      if (io_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = io_busy;
      if (done_cyc >= 0 && cyc == done_cyc + 2) busy_after2 = io_busy;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    io_start = 1'b0;
    io_pixReady = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (io_busy !== 1'b0 || io_pixValid !== 1'b0 || io_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: busy/valid/done got %b%b%b required 000",
               io_busy, io_pixValid, io_done);
    end
    n_checks++;
    if (io_writeX !== '0 || io_writeY !== '0 || io_pixColor !== '0) begin
      n_errors++;
      $display("FAIL reset_data: x=%0d y=%0d color=%h required 0 0 0",
               io_writeX, io_writeY, io_pixColor);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_shallow();
    int ex[7] = '{0, 1, 2, 3, 4, 5, 6};
    int ey[7] = '{1, 2, 2, 3, 3, 4, 4};
    int bad;
    run_line(0, 1, 6, 4, 12'hA5C, 0, -1, 0, 0, 100);
    n_checks++;
    if (got_x.size() != 7) begin
      n_errors++;
      $display("FAIL shallow_count: got %0d pixels required 7", got_x.size());
    end
    n_checks++;
    bad = 0;
    for (int i = 0; i < 7 && i < got_x.size(); i++) begin
      if (bad == 0 && (got_x[i] != ex[i] || got_y[i] != ey[i] || got_c[i] != 'hA5C)) begin
        bad = 1;
        n_errors++;
        $display("FAIL shallow_pix[%0d]: got (%0d,%0d,%h) required (%0d,%0d,a5c)",
                 i, got_x[i], got_y[i], got_c[i], ex[i], ey[i]);
      end
    end
    n_checks++;
    if (done_cyc - t_start != 9 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL shallow_done: got offset %0d count %0d required offset 9 count 1",
               done_cyc - t_start, done_cnt);
    end
    n_checks++;
    if (busy_after !== 1'b0) begin
      n_errors++;
      $display("FAIL shallow_busy: got busy %b after done required 0", busy_after);
    end
  endtask

  task automatic test_degenerate();
    run_line(32, 17, 32, 17, 12'h123, 0, -1, 0, 0, 50);
    n_checks++;
    if (got_x.size() != 1 || (got_x.size() == 1 && (got_x[0] != 32 || got_y[0] != 17))) begin
      n_errors++;
      $display("FAIL degenerate_pix: got %0d pixels first (%0d,%0d) required 1 pixel (32,17)",
               got_x.size(), got_x.size() > 0 ? got_x[0] : -1,
               got_y.size() > 0 ? got_y[0] : -1);
    end
    n_checks++;
    if (done_cyc - t_start != 3 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL degenerate_done: got offset %0d count %0d required offset 3 count 1",
               done_cyc - t_start, done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_line(0, 0, 255, 0, 12'hF0F, 0, 2, 3, 0, 400);
    n_checks++;
    if (hold_cyc != 4 || hold_bad != 0) begin
      n_errors++;
      $display("FAIL bp_hold: got %0d held cycles unstable=%0d required 4 stable", hold_cyc,
               hold_bad);
    end
    n_checks++;
    if (got_x.size() != 256) begin
      n_errors++;
      $display("FAIL bp_count: got %0d pixels required 256", got_x.size());
    end
    n_checks++;
    bad = 0;
    for (int i = 0; i < got_x.size(); i++) begin
      if (bad == 0 && (got_x[i] != i || got_y[i] != 0)) begin
        bad = 1;
        n_errors++;
        $display("FAIL bp_pix[%0d]: got (%0d,%0d) required (%0d,0)", i, got_x[i], got_y[i], i);
      end
    end
    n_checks++;
    if (done_cyc - t_start != 261) begin
      n_errors++;
      $display("FAIL bp_done: got offset %0d required 261", done_cyc - t_start);
    end
  endtask

  task automatic test_clip();
    int n_exp, x0, bad;
`ifdef LINE_RASTER_CLIP_EN
    n_exp = 5; x0 = 0;
`else
    n_exp = 10; x0 = -5;
`endif
    run_line(-5, 0, 4, 0, 12'h0AA, 0, -1, 0, 0, 100);
    n_checks++;
    if (got_x.size() != n_exp) begin
      n_errors++;
      $display("FAIL clip_count: got %0d pixels required %0d", got_x.size(), n_exp);
    end
    n_checks++;
    bad = 0;
    for (int i = 0; i < got_x.size(); i++) begin
      if (bad == 0 && (got_x[i] != x0 + i || got_y[i] != 0)) begin
        bad = 1;
        n_errors++;
        $display("FAIL clip_pix[%0d]: got (%0d,%0d) required (%0d,0)", i, got_x[i], got_y[i],
                 x0 + i);
      end
    end
    n_checks++;
    if (done_cyc - t_start != 12) begin
      n_errors++;
      $display("FAIL clip_done: got offset %0d required 12", done_cyc - t_start);
    end
  endtask

  task automatic test_random();
    int xs, ys, xe, ye, bad;
    logic [COLORW-1:0] col;
    for (int n = 0; n < 6; n++) begin
      xs = int'($urandom_range(0, 400)) - 40;
      ys = int'($urandom_range(0, 320)) - 40;
      xe = int'($urandom_range(0, 400)) - 40;
      ye = int'($urandom_range(0, 320)) - 40;
      col = COLORW'($urandom);
      model_line(xs, ys, xe, ye);
      run_line(xs, ys, xe, ye, col, 1, -1, 0, 0, 3000);
      n_checks++;
      bad = (got_x.size() != exp_x.size());
      for (int i = 0; i < got_x.size() && !bad; i++)
        if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_c[i] != int'(col)) bad = 1;
      if (bad) begin
        n_errors++;
        $display("FAIL rand_line%0d (%0d,%0d)->(%0d,%0d): got %0d pixels required %0d matching",
                 n, xs, ys, xe, ye, got_x.size(), exp_x.size());
      end
      n_checks++;
      if (done_cyc - t_start != 2 + exp_steps + stall_cyc || done_cnt != 1) begin
        n_errors++;
        $display("FAIL rand_done%0d: got offset %0d count %0d required offset %0d count 1",
                 n, done_cyc - t_start, done_cnt, 2 + exp_steps + stall_cyc);
      end
    end
  endtask

  task automatic test_start_ignore();
    int bad;
    model_line(10, 10, 20, 15);
    run_line(10, 10, 20, 15, 12'h5A5, 0, -1, 0, 5, 200);
    n_checks++;
    bad = (got_x.size() != exp_x.size());
    for (int i = 0; i < got_x.size() && !bad; i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_c[i] != 'h5A5) bad = 1;
    if (bad) begin
      n_errors++;
      $display("FAIL ignore_pix: got %0d pixels required %0d matching", got_x.size(),
               exp_x.size());
    end
    n_checks++;
    if (done_cnt != 1 || busy_after !== 1'b0 || busy_after2 !== 1'b0) begin
      n_errors++;
      $display("FAIL ignore_idle: got done count %0d busy %b%b required 1 and 00",
               done_cnt, busy_after, busy_after2);
    end
  endtask

  task automatic test_reset_midline();
    int seen_valid, seen_done;
    @(negedge clock);
    io_xs = 16'sd70; io_ys = 16'sd180; io_xe = 16'sd180; io_ye = 16'sd50;
    io_color = 12'hBEE;
    io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0;
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (io_busy !== 1'b0 || io_pixValid !== 1'b0 || io_done !== 1'b0 || io_writeX !== '0 ||
        io_writeY !== '0 || io_pixColor !== '0) begin
      n_errors++;
      $display("FAIL midreset_out: got busy=%b valid=%b done=%b x=%0d y=%0d c=%h required zeros",
               io_busy, io_pixValid, io_done, io_writeX, io_writeY, io_pixColor);
    end
    reset = 1'b0;
    seen_valid = 0;
    seen_done = 0;
    repeat (300) begin
      @(negedge clock);
      if (io_pixValid) seen_valid++;
      if (io_done) seen_done++;
    end
    n_checks++;
    if (seen_valid != 0 || seen_done != 0) begin
      n_errors++;
      $display("FAIL midreset_quiet: got %0d valid %0d done cycles required 0 0", seen_valid,
               seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_shallow();
    test_degenerate();
    test_backpressure();
    test_clip();
    test_random();
    test_start_ignore();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
